// File: rtl/chan_ctrl_pkg.sv
// Shared types, constants and helper functions for the channel configuration sequencer.
package chan_ctrl_pkg;

   typedef enum logic [1:0] {
      S_HOLD   = 2'd0,
      S_WAKE   = 2'd1,
      S_CONFIG = 2'd2,
      S_RUN    = 2'd3
   } chan_state_e;

   localparam logic [11:0] FFT_SIZE_MIN       = 12'd8;
   localparam logic [11:0] FFT_SIZE_MAX       = 12'd2048;
   localparam logic [11:0] DEFAULT_FFT_SIZE   = 12'd8;
   localparam logic [15:0] DEFAULT_PAYLOAD_M1 = 16'd63;

   // Index of the highest set bit; for valid power-of-two sizes this is log2(size).
   function automatic logic [4:0] nfft_encode(input logic [11:0] size);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 12; i++) begin
         if (size[i]) n = 5'(i);
      end
      return n;
   endfunction

   function automatic logic size_valid(input logic [11:0] size);
      return (size >= FFT_SIZE_MIN) && (size <= FFT_SIZE_MAX) &&
             ((size & (size - 12'd1)) == 12'd0);
   endfunction

endpackage

// File: rtl/chan_cfg_sequencer.sv
// Applies host FFT/payload configuration: resets the datapath, wakes and configures the FFT core.
// Optional config-handshake timeout is enabled by defining CHAN_CFG_TIMEOUT_EN.
module chan_cfg_sequencer
   import chan_ctrl_pkg::*;
#(
   parameter int unsigned RESET_HOLD     = 8,
   parameter int unsigned WAKE_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        sync_reset,
   input  logic        cfg_valid,
   input  logic [11:0] cfg_fft_size,
   input  logic [15:0] cfg_payload_length,
   output logic        cfg_ready,
   output logic [11:0] fft_size,
   output logic [15:0] payload_length_m1,
   output logic        dp_reset,
   output logic        fft_aresetn,
   output logic        fft_config_tvalid,
   output logic [15:0] fft_config_tdata,
   input  logic        fft_config_tready,
   output logic        busy,
   output logic        cfg_error,
   output logic        timeout
);

   localparam int unsigned HoldWakeMax = (RESET_HOLD > WAKE_CYCLES) ? RESET_HOLD : WAKE_CYCLES;
`ifdef CHAN_CFG_TIMEOUT_EN
   localparam int unsigned CntMax = (HoldWakeMax > TIMEOUT_CYCLES) ? HoldWakeMax : TIMEOUT_CYCLES;
`else
   localparam int unsigned CntMax = (TIMEOUT_CYCLES != 0) ? HoldWakeMax : HoldWakeMax;
`endif
   localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

   chan_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [11:0]     fft_size_q, fft_size_d;
   logic [15:0]     plm1_q, plm1_d;
   logic            cfg_error_q, cfg_error_d;
   logic            cfg_ready_q, dp_reset_q, fft_aresetn_q, tvalid_q, busy_q;
   logic [15:0]     tdata_q;
   logic            req_ok, accept;
   logic [15:0]     req_m1;
`ifdef CHAN_CFG_TIMEOUT_EN
   logic            timeout_q, timeout_d;
`endif

   assign req_ok = size_valid(cfg_fft_size) && (cfg_payload_length != 16'd0);
   assign req_m1 = cfg_payload_length - 16'd1;
   assign accept = cfg_valid && cfg_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fft_size_d  = fft_size_q;
      plm1_d      = plm1_q;
      cfg_error_d = cfg_error_q;
`ifdef CHAN_CFG_TIMEOUT_EN
      timeout_d   = timeout_q;
`endif
      unique case (state_q)
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_WAKE;
               cnt_d   = CntW'(WAKE_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAKE: begin
            if (cnt_q == '0) begin
               state_d = S_CONFIG;
`ifdef CHAN_CFG_TIMEOUT_EN
               cnt_d   = CntW'(TIMEOUT_CYCLES - 1);
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_CONFIG: begin
            if (fft_config_tready) begin
               state_d = S_RUN;
`ifdef CHAN_CFG_TIMEOUT_EN
            end else if (cnt_q == '0) begin
               timeout_d = 1'b1;
               state_d   = S_HOLD;
               cnt_d     = CntW'(RESET_HOLD - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
`endif
            end
         end
         S_RUN: begin
            if (accept) begin
               if (req_ok) begin
                  cfg_error_d = 1'b0;
`ifdef CHAN_CFG_TIMEOUT_EN
                  timeout_d   = 1'b0;
`endif
                  // An identical request only acknowledges; no resequencing.
                  if ((cfg_fft_size != fft_size_q) || (req_m1 != plm1_q)) begin
                     fft_size_d = cfg_fft_size;
                     plm1_d     = req_m1;
                     state_d    = S_HOLD;
                     cnt_d      = CntW'(RESET_HOLD - 1);
                  end
               end else begin
                  cfg_error_d = 1'b1;
               end
            end
         end
         default: state_d = S_HOLD;
      endcase
   end

   // Outputs are registered decodes of the next state so they line up with state_q.
   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         state_q       <= S_HOLD;
         cnt_q         <= CntW'(RESET_HOLD - 1);
         fft_size_q    <= DEFAULT_FFT_SIZE;
         plm1_q        <= DEFAULT_PAYLOAD_M1;
         cfg_error_q   <= 1'b0;
         cfg_ready_q   <= 1'b0;
         dp_reset_q    <= 1'b1;
         fft_aresetn_q <= 1'b0;
         tvalid_q      <= 1'b0;
         tdata_q       <= {11'd0, nfft_encode(DEFAULT_FFT_SIZE)};
         busy_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         fft_size_q    <= fft_size_d;
         plm1_q        <= plm1_d;
         cfg_error_q   <= cfg_error_d;
         cfg_ready_q   <= (state_d == S_RUN);
         dp_reset_q    <= (state_d != S_RUN);
         fft_aresetn_q <= (state_d != S_HOLD);
         tvalid_q      <= (state_d == S_CONFIG);
         tdata_q       <= {11'd0, nfft_encode(fft_size_d)};
         busy_q        <= (state_d != S_RUN);
      end
   end

`ifdef CHAN_CFG_TIMEOUT_EN
   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) timeout_q <= 1'b0;
      else            timeout_q <= timeout_d;
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign cfg_ready         = cfg_ready_q;
   assign fft_size          = fft_size_q;
   assign payload_length_m1 = plm1_q;
   assign dp_reset          = dp_reset_q;
   assign fft_aresetn       = fft_aresetn_q;
   assign fft_config_tvalid = tvalid_q;
   assign fft_config_tdata  = tdata_q;
   assign busy              = busy_q;
   assign cfg_error         = cfg_error_q;

endmodule

// File: doc/chan_cfg_sequencer.md
CHAN_CFG_SEQUENCER -- requirements
Module: chan_cfg_sequencer

Interface
REQ-001 Parameter RESET_HOLD, default 8: cycles the datapath reset and FFT aresetn are held asserted per sequence.
REQ-002 Parameter WAKE_CYCLES, default 2: cycles between aresetn release and the FFT config word being offered.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: config-handshake timeout; used only when CHAN_CFG_TIMEOUT_EN is defined.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 sync_reset  in  1  reset, asynchronous, active-high.
REQ-006 cfg_valid  in  1  host requests a new configuration.
REQ-007 cfg_fft_size  in  12  requested bin count.
REQ-008 cfg_payload_length  in  16  requested output packet length in samples.
REQ-009 cfg_ready  out  1  request accepted when cfg_valid and cfg_ready are both high.
REQ-010 fft_size  out  12  applied bin count, driven to the input buffer, PFB and shifter.
REQ-011 payload_length_m1  out  16  applied payload length minus one, driven to the final counter.
REQ-012 dp_reset  out  1  synchronous reset to the datapath blocks.
REQ-013 fft_aresetn  out  1  active-low reset to the FFT core.
REQ-014 fft_config_tvalid / fft_config_tdata / fft_config_tready  out/out/in  1/16/1  FFT config channel.
REQ-015 busy  out  1  high in every state except S_RUN.
REQ-016 cfg_error  out  1  sticky flag: last request was rejected.
REQ-017 timeout  out  1  sticky flag: config handshake timed out.

Function
REQ-018 FSM states: S_HOLD, S_WAKE, S_CONFIG, S_RUN.
REQ-019 S_HOLD behaviour:
- Outputs: dp_reset=1, fft_aresetn=0.
- Loads counter to RESET_HOLD-1 on entry and decrements each cycle.
- At counter 0, moves to S_WAKE.
REQ-020 S_WAKE behaviour:
- Outputs: dp_reset=1, fft_aresetn=1.
- After WAKE_CYCLES cycles, moves to S_CONFIG.
REQ-021 S_CONFIG behaviour:
- Outputs: fft_config_tvalid=1, fft_config_tdata={11'd0,nfft}, dp_reset=1.
- On the tvalid&tready cycle, moves to S_RUN; tvalid drops the next cycle.
REQ-022 S_RUN behaviour:
- Outputs: dp_reset=0, cfg_ready=1. cfg_ready is 0 in all other states.
- Requests arriving while not in S_RUN are stalled, not dropped.
REQ-023 nfft encoding: log2(fft_size) for the sizes 8,16,...,2048, which gives nfft 3..11.
REQ-024 Valid request (power-of-two fft_size in 8..2048 and payload_length != 0), on acceptance:
- Latches fft_size.
- Computes payload_length_m1 = payload_length - 1 with 16-bit wrap-free arithmetic.
- Clears cfg_error.
- Enters S_HOLD on the next cycle.
REQ-025 Invalid request: accepted for one cycle, sets cfg_error, leaves the applied configuration and state unchanged, and asserts no reset.
REQ-026 Request identical to the applied configuration: accepted and clears cfg_error, with no resequencing.
REQ-027 Latency from accepted valid request to S_RUN = 1 + RESET_HOLD + WAKE_CYCLES + config handshake cycles.
REQ-028 All outputs are registered; there is no combinational path from an input to an output.

Reset
REQ-029 While sync_reset is asserted, outputs are held at:
- State S_HOLD; fft_size=8, payload_length_m1=63.
- dp_reset=1, fft_aresetn=0, fft_config_tvalid=0, cfg_ready=0, busy=1, cfg_error=0, timeout=0.
REQ-030 On sync_reset deassertion, the block runs the full S_HOLD->S_RUN sequence with the default configuration.
REQ-031 sync_reset asserted mid-sequence or mid-handshake aborts immediately to the REQ-029 values; there is no partial config transfer afterwards.

Configuration
REQ-032 With CHAN_CFG_TIMEOUT_EN defined:
- S_CONFIG counts the cycles fft_config_tready stays low.
- At TIMEOUT_CYCLES, timeout is set and the block returns to S_HOLD to retry.
- timeout clears on the next accepted valid request.
REQ-033 Without CHAN_CFG_TIMEOUT_EN: S_CONFIG waits indefinitely, timeout is tied 0, and no timeout counter is synthesised.

Structure
REQ-034 Shared package chan_ctrl_pkg holds:
- the state enumeration;
- FFT size min/max constants;
- default fft_size/payload constants;
- the nfft encode function and the size-validity function.
REQ-035 No sub-module; a single module containing the FSM, the shared down-counter and the config registers.

Verification
REQ-036 Reset release with tready=1 -> dp_reset high for RESET_HOLD+WAKE_CYCLES+1 cycles; exactly one config beat with tdata=0x0003; busy falls.
REQ-037 In S_RUN, request fft_size=1024, payload=256 -> tdata=0x000A, fft_size=1024, payload_length_m1=255, dp_reset pulse seen.
REQ-038 Request fft_size=96 or payload=0 -> cfg_error=1, no dp_reset, outputs unchanged; a following valid request clears cfg_error.
REQ-039 Hold tready=0 for 40 cycles in S_CONFIG -> tvalid and tdata stable throughout; transfer completes on the first tready cycle.
REQ-040 CHAN_CFG_TIMEOUT_EN with TIMEOUT_CYCLES=16 and tready stuck 0 -> timeout=1 and re-entry to S_HOLD after 16 cycles; sync_reset asserted mid-S_WAKE -> REQ-029 values immediately.
